mem_write_checker: RTL
======================

# mem_write_checker

Synthesizable self-checking monitor for the multicycle CPU's data-memory write port. It holds a programmable list of up to DEPTH expected store events (address, data, optionally PC) and compares each `memwrite` strobe against the list in order. It reports pass, mismatch or timeout with the failing index and cycle count. It replaces hand-timed single-store checks in benches, and can also sit on-chip next to `cpu` for board-level self-test.

## Interface
- `DEPTH`, 8: expected-event capacity, ≥1.
- `ADDR_W`, 32: width of `dataaddr`/`pc`.
- `DATA_W`, 32: width of `writedata`.
- `TIMEOUT`, 256: maximum cycles allowed in RUN without a matching store, ≥1.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `load_valid`  input  1  expected-entry push request.
- `load_ready`  output  1  entry accepted when both valid and ready are high.
- `load_addr`  input  ADDR_W  expected store address.
- `load_data`  input  DATA_W  expected store data.
- `load_pc`  input  ADDR_W  expected PC at the store; present only with `MWC_PC_CHECK_EN`.
- `start`  input  1  begin monitoring.
- `clear`  input  1  synchronous return to IDLE and flush the list.
- `memwrite`  input  1  CPU store strobe.
- `dataaddr`  input  ADDR_W  CPU store address.
- `writedata`  input  DATA_W  CPU store data.
- `pc`  input  ADDR_W  CPU PC.
- `done`  output  1  high in PASS or FAIL.
- `pass`  output  1  high in PASS.
- `fail_code`  output  2  0 none, 1 mismatch, 2 timeout, 3 empty list.
- `fail_index`  output  $clog2(DEPTH) (min 1)  list index of the failing entry.
- `match_count`  output  $clog2(DEPTH+1)  stores matched so far.
- `cycle_count`  output  32  cycles spent in RUN; saturates at all-ones.

## Operation
- States: IDLE, RUN, PASS, FAIL. `reset` asserted forces IDLE; the list is emptied and every output is 0 except `load_ready`=1.
- IDLE:
  - `load_ready` = (entries < DEPTH). Accepted entries are appended in order.
  - A push attempted while full is dropped, and `load_ready` is 0.
- `start` in IDLE:
  - With entries > 0: go to RUN; head pointer, `match_count`, `cycle_count` and the idle counter are zeroed.
  - With entries = 0: go to FAIL, `fail_code`=3, `fail_index`=0.
- `start` together with an accepted push: the push is stored first, so the new entry counts.
- RUN:
  - `load_ready` = 0. `cycle_count` increments each cycle.
  - `memwrite`=1 at an edge: compare `dataaddr`/`writedata` (and `pc` when enabled) with the head entry.
    - Equal: `match_count`++, head advances, idle counter reset to 0. If this was the last entry, go to PASS.
    - Unequal: go to FAIL, `fail_code`=1, `fail_index`=head.
  - `memwrite`=0: idle counter increments. When it reaches TIMEOUT, go to FAIL, `fail_code`=2, `fail_index`=head.
  - A store and timeout expiry in the same cycle: the store wins and is evaluated.
- `memwrite` is ignored in IDLE, PASS and FAIL.
  - Stores after PASS do not change the verdict.
  - All status outputs hold until `clear` or reset.
- `clear` in any state: go to IDLE next edge. The list is flushed and all status outputs are zeroed. `clear` has priority over `start`, load and compare.
- Index arithmetic: the head pointer saturates at DEPTH-1. `match_count` never exceeds DEPTH.

## Timing
- All outputs are registered. A deciding edge N (final match, mismatch or timeout) shows `done`/`pass`/`fail_code` valid immediately after edge N.
- The store strobe is sampled one cycle per edge. A `memwrite` held high for k cycles counts as k stores.
- Latency, `start` to RUN: 1 edge. Timeout fires on the TIMEOUT-th consecutive store-free cycle in RUN.
- Reset takes effect asynchronously mid-RUN. Release is synchronous to the next `clk` rising edge.

## Configuration
- `MWC_PC_CHECK_EN` defined:
  - `load_pc` exists, and each entry stores the PC.
  - A match additionally requires `pc` == the stored PC. A PC difference alone gives `fail_code`=1.
- `MWC_PC_CHECK_EN` undefined:
  - No `load_pc` port and no PC storage.
  - `pc` is unused; only address and data are compared.

## Test plan
- Load (addr 1, data 1); start; store addr 1/data 1 at cycle 4 -> `pass`=1, `match_count`=1, `cycle_count`=4, `fail_code`=0.
- Load 3 entries (0x10/0xA, 0x14/0xB, 0x18/0xC); second store has data 0xBB -> FAIL, `fail_code`=1, `fail_index`=1, `match_count`=1.
- TIMEOUT=16, one entry loaded, no stores -> FAIL at RUN cycle 16, `fail_code`=2, `fail_index`=0.
- DEPTH=4: push 5 entries -> `load_ready` low after the 4th, 5th dropped. Start and match 4 stores -> `pass`=1, `match_count`=4.
- Start with empty list -> `fail_code`=3 next edge. Then `clear` -> IDLE, `done`=0, `load_ready`=1.
- Reset asserted mid-RUN after 1 of 2 matches -> all outputs 0 immediately, list empty. With `MWC_PC_CHECK_EN`: correct addr/data but wrong PC -> `fail_code`=1.

Source files
------------

// File: rtl/mem_write_checker.sv
// Store-event monitor for the CPU data-memory write port: compares each memwrite against a preloaded
// in-order list and reports pass/mismatch/timeout. Define MWC_PC_CHECK_EN to also store and compare the PC.
module mem_write_checker #(
  parameter  int DEPTH   = 8,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 256,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef MWC_PC_CHECK_EN
  input  logic [ADDR_W-1:0] load_pc,
`endif
  input  logic              start,
  input  logic              clear,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] pc,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  fail_index,
  output logic [CNT_W-1:0]  match_count,
  output logic [31:0]       cycle_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   head_q, head_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [1:0]         code_q, code_d;
  logic [IDX_W-1:0]   findex_q, findex_d;

  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic               push;
  logic               hit;
  logic               last;

  assign push = load_valid && load_ready;

  // Entry storage carries no reset; the list length lives in count_q.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      addr_mem[count_q[IDX_W-1:0]] <= load_addr;
      data_mem[count_q[IDX_W-1:0]] <= load_data;
    end
  end

`ifdef MWC_PC_CHECK_EN
  logic [ADDR_W-1:0] pc_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !clear) pc_mem[count_q[IDX_W-1:0]] <= load_pc;
  end

  assign hit = (addr_mem[head_q] == dataaddr) && (data_mem[head_q] == writedata) &&
               (pc_mem[head_q] == pc);
`else
  logic pc_unused;
  assign pc_unused = ^pc;
  assign hit = (addr_mem[head_q] == dataaddr) && (data_mem[head_q] == writedata);
`endif

  assign last = (CNT_W'(head_q) + CNT_W'(1)) == count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    head_d   = head_q;
    match_d  = match_q;
    cyc_d    = cyc_q;
    idle_d   = idle_q;
    code_d   = code_q;
    findex_d = findex_q;
    if (clear) begin
      state_d  = S_IDLE;
      count_d  = '0;
      head_d   = '0;
      match_d  = '0;
      cyc_d    = '0;
      idle_d   = '0;
      code_d   = 2'd0;
      findex_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push) count_d = count_q + CNT_W'(1);
          // A push in the same cycle as start already counts toward the list.
          if (start) begin
            if (push || (count_q != '0)) begin
              state_d = S_RUN;
              head_d  = '0;
              match_d = '0;
              cyc_d   = '0;
              idle_d  = '0;
            end else begin
              state_d  = S_FAIL;
              code_d   = 2'd3;
              findex_d = '0;
            end
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
          if (memwrite) begin
            if (hit) begin
              if (match_q != CNT_W'(DEPTH)) match_d = match_q + CNT_W'(1);
              if (head_q != IDX_W'(DEPTH - 1)) head_d = head_q + IDX_W'(1);
              idle_d = '0;
              if (last) state_d = S_PASS;
            end else begin
              state_d  = S_FAIL;
              code_d   = 2'd1;
              findex_d = head_q;
            end
          end else begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_d == IDLE_W'(TIMEOUT)) begin
              state_d  = S_FAIL;
              code_d   = 2'd2;
              findex_d = head_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      head_q   <= '0;
      match_q  <= '0;
      cyc_q    <= '0;
      idle_q   <= '0;
      code_q   <= 2'd0;
      findex_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      match_q  <= match_d;
      cyc_q    <= cyc_d;
      idle_q   <= idle_d;
      code_q   <= code_d;
      findex_q <= findex_d;
    end
  end

  assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass        = (state_q == S_PASS);
  assign load_ready  = (state_q == S_IDLE) && (count_q != CNT_W'(DEPTH));
  assign fail_code   = code_q;
  assign fail_index  = findex_q;
  assign match_count = match_q;
  assign cycle_count = cyc_q;

endmodule
